// File: rtl/pwm_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture_if
// Brief    : Peripheral-bus bundle of the PWM capture block (control + results).
// Revision : 1.0
// ============================================================================
interface pwm_capture_if;
    logic [31:0] ctrl_in;
    logic [31:0] period_out;
    logic [31:0] high_out;
    logic        cap_done;

    modport master (
        output ctrl_in,
        input  period_out,
        input  high_out,
        input  cap_done
    );

    modport slave (
        input  ctrl_in,
        output period_out,
        output high_out,
        output cap_done
    );
endinterface
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Brief    : Measures PWM period (as top = cycles-1) and high time (as cmp).
//            Optional glitch filter enabled by macro PWM_CAP_FILT_EN.
// Revision : 1.0
// ============================================================================
module pwm_capture #(
    parameter int CNT_W    = 27,
    parameter int FILT_LEN = 4
) (
    input  wire          CLK,
    input  wire          RSTn,
    input  wire          PWM_IN,
    pwm_capture_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ARM  = 2'd1;
    localparam logic [1:0] c_ST_HIGH = 2'd2;
    localparam logic [1:0] c_ST_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       r_sync;
    logic             w_sig;
    logic             r_sig_d;
    logic             w_rise;
    logic             w_fall;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_tout;
    logic             r_cap_done;

    logic             w_en;
    logic             w_clr;
    logic [CNT_W-1:0] w_tout_val;
    logic             w_tout_hit;
    logic             w_cap;
    logic             w_high_we;
    logic             w_tout_evt;
    logic             w_unused_ctrl;

    assign w_en          = bus.ctrl_in[31];
    assign w_clr         = bus.ctrl_in[30];
    assign w_tout_val    = bus.ctrl_in[CNT_W-1:0];
    assign w_unused_ctrl = ^bus.ctrl_in[29:CNT_W];

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_sync  <= 2'b00;
            r_sig_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], PWM_IN};
            r_sig_d <= w_sig;
        end
    end

`ifdef PWM_CAP_FILT_EN
    localparam int c_FILT_W = $clog2(FILT_LEN + 1);

    logic                r_sig_f;
    logic [c_FILT_W-1:0] r_filt_cnt;

    // sig follows the synchronised input only after FILT_LEN stable cycles
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_sig_f    <= 1'b0;
            r_filt_cnt <= '0;
        end else if (r_sync[1] == r_sig_f) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == c_FILT_W'(FILT_LEN - 1)) begin
            r_sig_f    <= r_sync[1];
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_sig = r_sig_f;
`else
    logic w_unused_filt;

    assign w_unused_filt = (FILT_LEN > 0);
    assign w_sig         = r_sync[1];
`endif

    assign w_rise     = w_sig & ~r_sig_d;
    assign w_fall     = ~w_sig & r_sig_d;
    assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_tout_hit = (w_tout_val != '0) && (r_cnt >= w_tout_val);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A relevant edge always takes priority over a timeout in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        if (!w_en) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: w_state_nxt = c_ST_ARM;
                c_ST_ARM: begin
                    if (w_rise)          w_state_nxt = c_ST_HIGH;
                    else if (w_tout_hit) w_state_nxt = c_ST_ARM;
                end
                c_ST_HIGH: begin
                    if (w_fall)          w_state_nxt = c_ST_LOW;
                    else if (w_tout_hit) w_state_nxt = c_ST_ARM;
                end
                c_ST_LOW: begin
                    if (w_rise)          w_state_nxt = c_ST_HIGH;
                    else if (w_tout_hit) w_state_nxt = c_ST_ARM;
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cap      = 1'b0;
        w_high_we  = 1'b0;
        w_tout_evt = 1'b0;
        w_cnt_nxt  = '0;
        if (w_en) begin
            case (r_state)
                c_ST_ARM: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_rise) begin
                        w_cnt_nxt = c_CNT_ONE;
                    end else if (w_tout_hit) begin
                        w_tout_evt = 1'b1;
                        w_cnt_nxt  = '0;
                    end
                end
                c_ST_HIGH: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_fall) begin
                        w_high_we = 1'b1;
                    end else if (w_tout_hit) begin
                        w_tout_evt = 1'b1;
                        w_cnt_nxt  = '0;
                    end
                end
                c_ST_LOW: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_rise) begin
                        w_cap     = 1'b1;
                        w_cnt_nxt = c_CNT_ONE;
                    end else if (w_tout_hit) begin
                        w_tout_evt = 1'b1;
                        w_cnt_nxt  = '0;
                    end
                end
                default: w_cnt_nxt = '0;
            endcase
        end
    end

    // Sticky status: a set event in the same cycle beats clr_sts
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_cnt      <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_tout     <= 1'b0;
            r_cap_done <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_cap_done <= w_cap;
            if (w_high_we) r_high <= r_cnt;
            if (w_cap)     r_period <= r_cnt - 1'b1;
            if (w_cap)          r_valid <= 1'b1;
            else if (w_clr)     r_valid <= 1'b0;
            if (w_tout_evt)     r_tout <= 1'b1;
            else if (w_clr)     r_tout <= 1'b0;
        end
    end

    assign bus.period_out = {r_valid, r_tout, {(30 - CNT_W){1'b0}}, r_period};
    assign bus.high_out   = {{(32 - CNT_W){1'b0}}, r_high};
    assign bus.cap_done   = r_cap_done;

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- PWM input-capture block: the receive-side counterpart of the team's 27-bit timer/PWM generator.
- Measures period and high time of an external PWM signal, in CLK cycles.
- Reports results in the generator's own encoding: period as "top" (cycles-1), high time as "cmp" (cycles). A captured waveform can therefore be reprogrammed into a generator unchanged.
- Sits on the peripheral bus next to the generator; software reads the two capture words.

Parameters:
- CNT_W, 27, counter/result width; matches generator top/cmp field width.
- FILT_LEN, 4, glitch-filter stability length in cycles; used only with PWM_CAP_FILT_EN.

Ports:
- CLK  input  1  clock.
- RSTn  input  1  synchronous active-low reset.
- PWM_IN  input  1  asynchronous PWM signal to measure.
- ctrl_in  input  32  [31]=en, [30]=clr_sts (level, clears status while 1), [29:27] reserved, [26:0]=timeout in cycles (0 = timeout disabled).
- period_out  output  32  [31]=data_valid sticky, [30]=timeout sticky, [29:27]=0, [26:0]=period cycles-1.
- high_out  output  32  [31:27]=0, [26:0]=high cycles.
- cap_done  output  1  one-cycle pulse when a new period/high pair is written.

Behaviour:
- Reset: RSTn sampled on posedge CLK; when 0, all registers clear: synchroniser, filter, state=IDLE, cnt=0, period_out=0, high_out=0, cap_done=0. Reset mid-measurement discards the partial result.
- Input path: 2-flop synchroniser -> (optional filter) -> sig; sig_d = sig delayed one cycle, always updated, even when disabled.
  - rise = sig & ~sig_d; fall = ~sig & sig_d.
  - Edge-detect latency is 2 cycles after PWM_IN changes (plus FILT_LEN with the filter). Latency is identical for both edges, so measured widths are exact.
- Counter cnt (CNT_W bits): saturates at all-ones, never wraps.
- State IDLE: en=0. cnt=0; outputs and status hold their last values. en=1 -> ARM.
- State ARM: waits for rise; any partial pulse present at enable is ignored. On rise: cnt<=1, go to HIGH.
- State HIGH: cnt increments each cycle. On fall: high_out[26:0]<=cnt, go to LOW.
- State LOW: cnt increments each cycle. On rise:
  - period_out[26:0]<=cnt-1, data_valid<=1, cap_done=1 for that cycle.
  - cnt<=1, go to HIGH. Measurement is continuous: each rise both ends one period and starts the next.
- Timing identity: a generator with top=T, cmp=C (0<C<=T) yields high=C and period field=T.
- Timeout (timeout!=0): in ARM/HIGH/LOW, when cnt>=timeout and no edge occurs this cycle:
  - timeout sticky<=1, cnt<=0, go to ARM.
  - Captured values are not changed.
  - In ARM, cnt also counts (from 0) for timeout purposes.
- Simultaneous events:
  - An edge in the same cycle as a timeout condition: the edge wins.
  - clr_sts=1 clears data_valid and timeout sticky; a capture or timeout set in the same cycle wins (bit reads 1).
  - en falling to 0 mid-measurement -> IDLE next cycle; the partial result is discarded and no cap_done is issued.
- Constant-level input (cmp=0 or cmp>top on the generator): no edges occur, so no cap_done; only a timeout is reported, if enabled.
- Reserved input bits are ignored.

Optional Feature:
- Macro PWM_CAP_FILT_EN.
- Defined: digital glitch filter between synchroniser and edge detect.
  - sig changes only after the synchronised input has differed from sig for FILT_LEN consecutive cycles.
  - Shorter pulses are suppressed entirely.
  - Adds FILT_LEN cycles of latency to every edge; measured widths are unchanged.
- Undefined: sig = synchroniser output; no filter logic or FILT_LEN counter is instantiated.

Test Plan:
- Loopback: generator top=9, cmp=3, en=1; capture en=1, timeout=0 -> from the 2nd rise onward, cap_done every 10 cycles; period_out=0x80000009, high_out=0x00000003.
- PWM_IN held low, timeout=100, en=1 -> ~100 cycles after enable, period_out[30]=1, cap_done never pulses. Then clr_sts=1 for one cycle -> period_out[31:30]=00.
- Enable while PWM_IN already high (mid-pulse) -> first high_out reflects only the next full pulse. With a 5-high/5-low input: high=5, period field=9.
- Manual waveform 3 high / 2 low, then RSTn=0 for one cycle during a high phase -> all outputs 0. After reset and en, the next full cycle gives high=3, period field=4.
- Edge and timeout together: timeout=6, input 6-cycle high -> the fall is detected on the cycle cnt reaches 6. Required: high_out=6, no timeout flag.
- With PWM_CAP_FILT_EN, FILT_LEN=4: a 2-cycle glitch inside a 20-cycle low phase -> ignored; period/high equal the glitch-free values. Without the macro, the same glitch yields cap_done pulses with high=2.
